reg_file: RTL and testbench

//  Single-port synchronous register file, DEPTH words x DATAWIDTH bits, one clock.

---
 rtl/reg_file_if.sv | 30 +++
 rtl/reg_file.sv | 76 +++++++
 tb/tb_reg_file.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// reg_file_if
//   Bus between a requester and the register file.
//   Requester -> reg file : Address, WrEn, RdEn, WrData
//   Reg file -> requester : RdData, RdData_Valid, REG0..REG3 (live copies of words 0-3)
//   Modports: master (requester side), slave (register file side).
interface reg_file_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDR      = 4
);
    logic [ADDR-1:0]      Address;
    logic                 WrEn;
    logic                 RdEn;
    logic [DATAWIDTH-1:0] WrData;
    logic [DATAWIDTH-1:0] RdData;
    logic                 RdData_Valid;
    logic [DATAWIDTH-1:0] REG0;
    logic [DATAWIDTH-1:0] REG1;
    logic [DATAWIDTH-1:0] REG2;
    logic [DATAWIDTH-1:0] REG3;

    modport master (
        output Address, WrEn, RdEn, WrData,
        input  RdData, RdData_Valid, REG0, REG1, REG2, REG3
    );

    modport slave (
        input  Address, WrEn, RdEn, WrData,
        output RdData, RdData_Valid, REG0, REG1, REG2, REG3
    );
endinterface

// File: rtl/reg_file.sv
// reg_file
//   Single-port register file, DEPTH x DATAWIDTH, with registered read and a
//   one-cycle read-valid strobe. Words 0-3 hold system configuration and are
//   exported continuously on REG0..REG3:
//     REG0 ALU operand A, REG1 ALU operand B,
//     REG2 UART config ([0] parity en, [1] parity type, [7:2] prescale),
//     REG3 clock divider ratio.
// Ports
//   CLK  clock, rising edge
//   RST  asynchronous active-high reset
//   bus  reg_file_if.slave: Address, WrEn, RdEn, WrData in;
//        RdData, RdData_Valid, REG0..REG3 out
// Build option
//   REGFILE_RDCLR_EN : when defined, RdData is cleared on every edge that does
//                      not carry a valid read; otherwise RdData holds.
module reg_file #(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR      = 4
) (
    input  logic       CLK,
    input  logic       RST,
    reg_file_if.slave  bus
);

    localparam logic [DATAWIDTH-1:0] REG2_RST = DATAWIDTH'(8'h81);
    localparam logic [DATAWIDTH-1:0] REG3_RST = DATAWIDTH'(8'h20);

    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [DATAWIDTH-1:0] rd_data;
    logic                 rd_vld;

    // Simultaneous WrEn/RdEn is treated as no access at all.
    logic wr_go;
    logic rd_go;
    assign wr_go = bus.WrEn & ~bus.RdEn;
    assign rd_go = bus.RdEn & ~bus.WrEn;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            mem[2] <= REG2_RST;
            mem[3] <= REG3_RST;
        end else if (wr_go) begin
            mem[bus.Address] <= bus.WrData;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= rd_go;
            if (rd_go) begin
                rd_data <= mem[bus.Address];
            end
`ifdef REGFILE_RDCLR_EN
            else begin
                rd_data <= '0;
            end
`else
`endif
        end
    end

    assign bus.RdData       = rd_data;
    assign bus.RdData_Valid = rd_vld;
    assign bus.REG0         = mem[0];
    assign bus.REG1         = mem[1];
    assign bus.REG2         = mem[2];
    assign bus.REG3         = mem[3];

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file
//   Directed and random stimulus against an array-based reference model of
//   the register file; all outputs compared after every clock edge.
module tb_reg_file;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    reg_file_if #(.DATAWIDTH(8), .ADDR(4)) bus ();

    reg_file #(.DATAWIDTH(8), .DEPTH(16), .ADDR(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain array plus expected read outputs.
    logic [7:0] mdl [16];
    logic [7:0] exp_rd;
    logic       exp_vld;

    task automatic mdl_reset();
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        mdl[2]  = 8'h81;
        mdl[3]  = 8'h20;
        exp_rd  = 8'h00;
        exp_vld = 1'b0;
    endtask

    // One clock edge as seen by the model.
    task automatic mdl_edge(input logic we, input logic re, input logic [3:0] a, input logic [7:0] d);
        if (we && !re) begin
            mdl[a]  = d;
            exp_vld = 1'b0;
`ifdef REGFILE_RDCLR_EN
            exp_rd  = 8'h00;
`endif
        end else if (re && !we) begin
            exp_rd  = mdl[a];
            exp_vld = 1'b1;
        end else begin
            exp_vld = 1'b0;
`ifdef REGFILE_RDCLR_EN
            exp_rd  = 8'h00;
`endif
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_rddata"}, bus.RdData, exp_rd);
        chk({tag, "_rdvalid"}, {7'd0, bus.RdData_Valid}, {7'd0, exp_vld});
        chk({tag, "_reg0"}, bus.REG0, mdl[0]);
        chk({tag, "_reg1"}, bus.REG1, mdl[1]);
        chk({tag, "_reg2"}, bus.REG2, mdl[2]);
        chk({tag, "_reg3"}, bus.REG3, mdl[3]);
    endtask

    task automatic step(input string tag, input logic we, input logic re,
                        input logic [3:0] a, input logic [7:0] d);
        @(negedge CLK);
        bus.WrEn    = we;
        bus.RdEn    = re;
        bus.Address = a;
        bus.WrData  = d;
        @(posedge CLK);
        mdl_edge(we, re, a, d);
        #1;
        check_all(tag);
    endtask

    initial begin
        bus.WrEn    = 1'b0;
        bus.RdEn    = 1'b0;
        bus.Address = 4'h0;
        bus.WrData  = 8'h00;

        // 1: asynchronous reset mid-cycle, no clock edge in between
        #2 RST = 1'b1;
        #1;
        mdl_reset();
        check_all("async_rst");
        @(posedge CLK); #1;
        check_all("rst_hold");
        @(negedge CLK);
        RST = 1'b0;

        // 2: write then read 0xA, then release RdEn
        step("wr_a",   1'b1, 1'b0, 4'hA, 8'h88);
        step("rd_a",   1'b0, 1'b1, 4'hA, 8'h00);
        chk("rd_a_direct", bus.RdData, 8'h88);
        step("idle_a", 1'b0, 1'b0, 4'hA, 8'h00);

        // 3: back-to-back reads
        step("wr_f",   1'b1, 1'b0, 4'hF, 8'h8B);
        step("rd_f",   1'b0, 1'b1, 4'hF, 8'h00);
        step("rd_a2",  1'b0, 1'b1, 4'hA, 8'h00);
        step("idle_b", 1'b0, 1'b0, 4'h0, 8'h00);

        // 4: configuration words
        step("wr_0",   1'b1, 1'b0, 4'h0, 8'h05);
        chk("reg0_direct", bus.REG0, 8'h05);
        step("wr_3",   1'b1, 1'b0, 4'h3, 8'h33);
        chk("reg3_direct", bus.REG3, 8'h33);

        // 5: both enables: no access
        step("wr_rd",  1'b1, 1'b1, 4'h2, 8'hFF);
        chk("reg2_kept", bus.REG2, 8'h81);

        // reads of words 0-3 match REGk
        for (int k = 0; k < 4; k++) step("rd_cfg", 1'b0, 1'b1, 4'(k), 8'h00);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            logic we, re;
            we = ($urandom_range(0, 99) < 40);
            re = ($urandom_range(0, 99) < 45);
            step("rand", we, re, 4'($urandom_range(0, 15)), 8'($urandom));
        end

        // 6: reset during a pending read
        step("wr_a3",  1'b1, 1'b0, 4'hA, 8'h88);
        step("rd_a3",  1'b0, 1'b1, 4'hA, 8'h00);
        @(negedge CLK);
        bus.WrEn    = 1'b0;
        bus.RdEn    = 1'b1;
        bus.Address = 4'hA;
        #2 RST = 1'b1;
        #1;
        mdl_reset();
        check_all("rst_in_rd");
        @(posedge CLK); #1;
        check_all("rst_in_rd_hold");
        @(negedge CLK);
        RST = 1'b0;
        bus.RdEn = 1'b0;
        step("idle_c", 1'b0, 1'b0, 4'h0, 8'h00);
        step("rd_a4",  1'b0, 1'b1, 4'hA, 8'h00);
        chk("rd_a4_direct", bus.RdData, 8'h00);
        step("idle_d", 1'b0, 1'b0, 4'h0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
